udma_l2_port_arbiter: RTL

UDMA_L2_PORT_ARBITER -- requirements
Module: udma_l2_port_arbiter

---
 rtl/udma_l2_port_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/udma_l2_port_arbiter.sv
// Two-requester (read-only / write-only) arbiter onto a shared L2 port.
// Tracks granted-but-unanswered transactions in an owner FIFO to route responses.
module udma_l2_port_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_resetn_i,

    input  logic                    ro_req_i,
    output logic                    ro_gnt_o,
    input  logic [31:0]             ro_addr_i,
    output logic                    ro_rvalid_o,
    output logic [DATA_WIDTH-1:0]   ro_rdata_o,

    input  logic                    wo_req_i,
    output logic                    wo_gnt_o,
    input  logic [31:0]             wo_addr_i,
    input  logic [DATA_WIDTH-1:0]   wo_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wo_be_i,
    output logic                    wo_rvalid_o,

    output logic                    l2_req_o,
    input  logic                    l2_gnt_i,
    output logic [31:0]             l2_addr_o,
    output logic                    l2_wen_o,
    output logic [DATA_WIDTH/8-1:0] l2_be_o,
    output logic [DATA_WIDTH-1:0]   l2_wdata_o,
    input  logic                    l2_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   l2_rdata_i
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    localparam logic OWN_RO = 1'b0;
    localparam logic OWN_WO = 1'b1;

    logic                       prio_q;
    logic                       lock_q;
    logic                       lock_owner_q;
    logic [31:0]                lock_addr_q;
    logic                       lock_wen_q;
    logic [BE_W-1:0]            lock_be_q;
    logic [DATA_WIDTH-1:0]      lock_wdata_q;

    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic [PTR_W-1:0]           wr_ptr_q;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [CNT_W-1:0]           count_q;

    logic                       owner;
    logic [31:0]                live_addr;
    logic                       live_wen;
    logic [BE_W-1:0]            live_be;
    logic [DATA_WIDTH-1:0]      live_wdata;
    logic                       can_issue;
    logic                       accept;
    logic                       stall;
    logic                       fifo_empty;
    logic                       pop;
    logic                       head;

    // A stalled request keeps its owner and payload until the L2 side accepts it.
    always_comb begin
        owner = OWN_RO;
        if (lock_q) begin
            owner = lock_owner_q;
        end else if (ro_req_i && wo_req_i) begin
            owner = prio_q;
        end else if (wo_req_i) begin
            owner = OWN_WO;
        end
    end

    always_comb begin
        live_addr  = ro_addr_i;
        live_wen   = 1'b1;
        live_be    = '1;
        live_wdata = '0;
        if (owner == OWN_WO) begin
            live_addr  = wo_addr_i;
            live_wen   = 1'b0;
            live_be    = wo_be_i;
            live_wdata = wo_wdata_i;
        end
    end

    assign l2_addr_o  = lock_q ? lock_addr_q  : live_addr;
    assign l2_wen_o   = lock_q ? lock_wen_q   : live_wen;
    assign l2_be_o    = lock_q ? lock_be_q    : live_be;
    assign l2_wdata_o = lock_q ? lock_wdata_q : live_wdata;

    // Full check uses the registered count, so a same-cycle pop does not reopen issue.
    assign can_issue = (count_q < CNT_W'(MAX_OUTSTANDING));
    assign l2_req_o  = (ro_req_i | wo_req_i) & can_issue;
    assign accept    = l2_req_o & l2_gnt_i;
    assign stall     = l2_req_o & ~l2_gnt_i;

    assign ro_gnt_o  = accept & (owner == OWN_RO);
    assign wo_gnt_o  = accept & (owner == OWN_WO);

    assign fifo_empty  = (count_q == '0);
    assign pop         = l2_rvalid_i & ~fifo_empty;
    assign head        = fifo_q[rd_ptr_q];
    assign ro_rvalid_o = pop & (head == OWN_RO);
    assign wo_rvalid_o = pop & (head == OWN_WO);
    assign ro_rdata_o  = l2_rdata_i;

    always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
        if (!sys_resetn_i) begin
            prio_q       <= OWN_RO;
            lock_q       <= 1'b0;
            lock_owner_q <= OWN_RO;
            lock_addr_q  <= '0;
            lock_wen_q   <= 1'b0;
            lock_be_q    <= '0;
            lock_wdata_q <= '0;
        end else begin
            lock_q <= stall;
            if (stall) begin
                lock_owner_q <= owner;
                lock_addr_q  <= l2_addr_o;
                lock_wen_q   <= l2_wen_o;
                lock_be_q    <= l2_be_o;
                lock_wdata_q <= l2_wdata_o;
            end
            if (accept && ro_req_i && wo_req_i) begin
                prio_q <= ~owner;
            end
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
        if (!sys_resetn_i) begin
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                fifo_q[wr_ptr_q] <= owner;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(accept) - CNT_W'(pop);
        end
    end

endmodule
